seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
// - Clocked, parametrised successor to the combinational datapath ALU. Adds a registered
//   result and {carry, neg, zero} flags, a valid/ready handshake on both sides, and
//   multi-bit shifts iterated one bit per clock.
// - Sits between the register file read ports and writeback. The controller stalls on
//   in_ready/out_valid, so multi-cycle ops need no fixed pipeline timing.
// PARAMETERS
// - WIDTH   8   datapath width in bits, >=2
// - SHW     $clog2(WIDTH)+1   width of shift amount taken from input_B[SHW-1:0]
// PORTS
// - clk        in   1      single clock, rising edge
// - reset      in   1      synchronous, active-high
// - in_valid   in   1      op/operands valid
// - in_ready   out  1      block can accept; =1 only in IDLE
// - op         in   4      operation code, see BEHAVIOUR
// - input_A    in   WIDTH  operand A
// - input_B    in   WIDTH  operand B / shift amount
// - out_valid  out  1      result and flags valid; held until out_ready
// - out_ready  in   1      consumer accepts result
// - out        out  WIDTH  registered result
// - flags      out  3      registered {carry, neg, zero}
// BEHAVIOUR
// - Reset: IDLE, out=0, flags=3'b000, out_valid=0, in_ready=1, carry register cleared.
//   Reset mid-operation aborts the op; no result is produced.
// - Ops: 0 NOT A; 1 AND; 2 OR; 3 XOR; 4 ADD A+B; 5 SUB A+~B+1; 6 ADC A+B+carry_q;
//   7 SHL; 8 SHR logical; 9 SRA; 10 ZERO; 11 ONE (=1); 12 MUL (macro); others illegal.
// - Illegal op (incl. 12 without macro): out=0, zero=1, neg=0, carry preserved; latency 1.
// - Arithmetic is WIDTH-bit wraparound. ADD/ADC carry = bit WIDTH of the sum.
//   SUB carry = no-borrow (1 iff A>=B unsigned).
// - neg=out[WIDTH-1] and zero=~|out for every completed op. Carry is updated only by
//   ADD/SUB/ADC/shifts/MUL; all other ops preserve it.
// - FSM: IDLE --accept--> DONE (single-cycle ops, or shift with amt=0) or BUSY (shift
//   amt>0, MUL); BUSY --count exhausted--> DONE; DONE --out_ready--> IDLE.
// - Accept = in_valid & in_ready. Operands are latched at accept; input changes after
//   accept are ignored. in_ready=0 in BUSY and DONE, so there is no overlapped accept.
// - Latency from the accept edge k: out_valid rises after edge k+1 for single-cycle ops;
//   after k+1+min(amt,WIDTH) for shifts; after k+1+WIDTH for MUL.
// - Shifts: amt=input_B[SHW-1:0], saturated at WIDTH. One bit moves per BUSY cycle.
//   carry = last bit shifted out. amt>=WIDTH gives 0 for SHL/SHR and all sign bits for
//   SRA, with carry=last bit out. amt=0: out=A, carry preserved.
// - DONE: out, flags and out_valid are stable until out_ready=1. The handshake completes
//   on that edge and out_valid drops next cycle. out and flags keep their value in IDLE.
// - out_ready is ignored while out_valid=0.
// CONFIGURATION
// - SEQ_ALU_MUL_EN defined: op 12 is an unsigned shift-add multiply, WIDTH BUSY cycles.
//   out = low WIDTH bits of A*B; carry=1 iff the high WIDTH bits are nonzero.
// - SEQ_ALU_MUL_EN undefined: no multiplier logic; op 12 is treated as illegal.
// TESTING (WIDTH=8)
// - ADD FF+01 -> out 00, flags c1 n0 z1, out_valid one cycle after accept.
// - SUB 05-07 -> FE, c0 n1 z0. Then ADC 00+00 -> 00, c0.
//   Also ADD FF+FF (c1) followed by ADC 01+01 -> 03.
// - SHL 81 by 3 -> 08, c0, out_valid 4 cycles after accept. SRA 80 by 9 -> FF, c1,
//   8 BUSY cycles (saturated).
// - Backpressure: out_ready low 5 cycles after completion -> out/flags/out_valid held,
//   in_ready=0, and a new in_valid is not accepted until the cycle after out_ready.
// - Reset asserted on 2nd BUSY cycle of SHR by 6 -> next cycle IDLE, out_valid 0,
//   out 00, flags 000, in_ready 1.
// - With SEQ_ALU_MUL_EN: 0F*11 -> FF c0; 10*10 -> 00 c1 z1, 8 BUSY cycles.
//   Without it: op 12 -> 00 z1, carry unchanged, latency 1.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with registered result/flags, valid/ready handshake, bit-serial shifts.
// Ports: clk, reset (sync, active-high); in_valid/in_ready, op[3:0], input_A, input_B accept side;
// out_valid/out_ready, out[WIDTH-1:0], flags[2:0]={carry,neg,zero} result side.
// Optional: define SEQ_ALU_MUL_EN to enable op 12, a WIDTH-cycle unsigned shift-add multiply.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       flags
);
  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_ADC = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_ZERO = 4'd10;
  localparam logic [3:0] OP_ONE = 4'd11;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd12;
`endif
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state;
  logic r_in_ready;
  logic r_out_valid;
  logic [3:0] r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out;
  logic [2:0] r_flags;
  logic [SHW-1:0] r_cnt;
  logic r_sc;
  logic w_is_shift;
  logic [SHW-1:0] w_amt;
  logic [WIDTH-1:0] w_step;
  logic w_step_c;
  logic [WIDTH-1:0] w_bop;
  logic w_cin;
  logic [WIDTH:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic w_c;
  assign in_ready = r_in_ready;
  assign out_valid = r_out_valid;
  assign out = r_out;
  assign flags = r_flags;
  assign w_is_shift = op == OP_SHL || op == OP_SHR || op == OP_SRA;
  assign w_amt = input_B[SHW-1:0] > SHW'(WIDTH) ? SHW'(WIDTH) : input_B[SHW-1:0];
`ifdef SEQ_ALU_MUL_EN
  // Multiply keeps the running high half in r_acc and the multiplier/low half in r_b.
  logic [WIDTH:0] w_mul_add;
  assign w_mul_add = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
`endif
  always_comb begin
    w_step = r_op == OP_SHL ? {r_acc[WIDTH-2:0], 1'b0} : {r_op == OP_SRA && r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    w_step_c = r_op == OP_SHL ? r_acc[WIDTH-1] : r_acc[0];
`ifdef SEQ_ALU_MUL_EN
    if (r_op == OP_MUL) w_step = w_mul_add[WIDTH:1];
`endif
  end
  // SUB as A + ~B + 1 so bit WIDTH of the sum is the no-borrow carry.
  assign w_bop = r_op == OP_SUB ? ~r_b : r_b;
  assign w_cin = r_op == OP_SUB ? 1'b1 : r_op == OP_ADC ? r_flags[2] : 1'b0;
  assign w_sum = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
  always_comb begin
    w_res = '0;
    w_c = r_flags[2];
    case (r_op)
      OP_NOT: w_res = ~r_a;
      OP_AND: w_res = r_a & r_b;
      OP_OR: w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_ADD, OP_SUB, OP_ADC: {w_c, w_res} = w_sum;
      OP_SHL, OP_SHR, OP_SRA: begin
        w_res = r_acc;
        w_c = r_sc;
      end
      OP_ZERO: w_res = '0;
      OP_ONE: w_res = WIDTH'(1);
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: begin
        w_res = r_b;
        w_c = |r_acc;
      end
`endif
      default: w_res = '0;
    endcase
  end
  // BUSY always ends with one r_cnt==0 cycle that registers the result, giving the
  // k+1+count latency; r_sc starts as the old carry so a zero-length shift preserves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_out <= '0;
      r_flags <= '0;
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_sc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid && r_in_ready) begin
          r_op <= op;
          r_a <= input_A;
          r_b <= input_B;
          r_sc <= r_flags[2];
`ifdef SEQ_ALU_MUL_EN
          r_acc <= op == OP_MUL ? '0 : input_A;
          r_cnt <= w_is_shift ? w_amt : op == OP_MUL ? SHW'(WIDTH) : '0;
`else
          r_acc <= input_A;
          r_cnt <= w_is_shift ? w_amt : '0;
`endif
          r_in_ready <= 1'b0;
          r_state <= S_BUSY;
        end
        S_BUSY: if (r_cnt != '0) begin
          r_cnt <= r_cnt - SHW'(1);
          r_acc <= w_step;
          r_sc <= w_step_c;
`ifdef SEQ_ALU_MUL_EN
          if (r_op == OP_MUL) r_b <= {w_mul_add[0], r_b[WIDTH-1:1]};
`endif
        end else begin
          r_out <= w_res;
          r_flags <= {w_c, w_res[WIDTH-1], ~|w_res};
          r_out_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
